// File: rtl/mips32_prog_loader.sv
// Framed byte-stream loader: assembles big-endian words and writes them into CPU memory.
// Define MIPS32_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte before release.
module mips32_prog_loader #(
   parameter int AW = 10
) (
   input  logic          clk1_i,
   input  logic          rst_n_i,
   input  logic [7:0]    in_data_i,
   input  logic          in_valid_i,
   output logic          in_ready_o,
   input  logic          reload_i,
   output logic          mem_we_o,
   output logic [AW-1:0] mem_addr_o,
   output logic [31:0]   mem_wdata_o,
   output logic          cpu_halt_o,
   output logic [AW-1:0] pc_start_o,
   output logic          done_o,
   output logic          err_o
);

   typedef enum logic [3:0] {
      S_IDLE, S_A_LO, S_C_HI, S_C_LO, S_DATA, S_WRITE, S_CHK, S_DONE, S_ERR
   } state_e;

`ifdef MIPS32_LOADER_CHECKSUM_EN
   localparam state_e S_TAIL = S_CHK;
`else
   localparam state_e S_TAIL = S_DONE;
`endif
   localparam bit TAIL_DONE = (S_TAIL == S_DONE);

   state_e        state_q;
   logic [AW-1:0] addr_q, addr_d, start_q;
   logic [15:0]   cnt_q, cnt_d, cnt_lo_d;
   logic [31:0]   word_q, word_d;
   logic [1:0]    bidx_q;
   logic          in_ready_q, mem_we_q, cpu_halt_q, done_q;
   logic [AW-1:0] mem_addr_q, pc_start_q;
   logic [31:0]   mem_wdata_q;
   logic          xfer, fin, chk_ok, chk_bad, go_done;

   assign xfer     = in_valid_i & in_ready_q;
   assign word_d   = {word_q[23:0], in_data_i};
   assign addr_d   = addr_q + AW'(1);
   assign cnt_d    = cnt_q - 16'd1;
   assign cnt_lo_d = {cnt_q[15:8], in_data_i};

   // Last word written, or an empty frame: move on to the checksum byte or straight to DONE.
   assign fin = (state_q == S_C_LO && xfer && cnt_lo_d == 16'd0) ||
                (state_q == S_WRITE && cnt_q == 16'd1);

`ifdef MIPS32_LOADER_CHECKSUM_EN
   logic [7:0] csum_q;
   logic       err_q;

   assign chk_ok  = (state_q == S_CHK) && xfer && (in_data_i == csum_q);
   assign chk_bad = (state_q == S_CHK) && xfer && (in_data_i != csum_q);

   always_ff @(posedge clk1_i or negedge rst_n_i) begin
      if (!rst_n_i)
         csum_q <= 8'h00;
      else if (xfer)
         csum_q <= (state_q == S_IDLE) ? in_data_i : (csum_q ^ in_data_i);
   end

   assign err_o = err_q;
`else
   assign chk_ok  = 1'b0;
   assign chk_bad = 1'b0;
   assign err_o   = 1'b0;
`endif

   assign go_done = (fin && TAIL_DONE) || chk_ok;

   always_ff @(posedge clk1_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q     <= S_IDLE;
         addr_q      <= '0;
         start_q     <= '0;
         cnt_q       <= '0;
         word_q      <= '0;
         bidx_q      <= '0;
         in_ready_q  <= 1'b1;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         cpu_halt_q  <= 1'b1;
         pc_start_q  <= '0;
         done_q      <= 1'b0;
`ifdef MIPS32_LOADER_CHECKSUM_EN
         err_q       <= 1'b0;
`endif
      end else begin
         mem_we_q <= 1'b0;
         case (state_q)
            S_IDLE: if (xfer) begin
               addr_q  <= AW'({in_data_i, 8'h00});
               state_q <= S_A_LO;
            end
            S_A_LO: if (xfer) begin
               addr_q  <= addr_q | AW'(in_data_i);
               start_q <= addr_q | AW'(in_data_i);
               state_q <= S_C_HI;
            end
            S_C_HI: if (xfer) begin
               cnt_q   <= {in_data_i, 8'h00};
               state_q <= S_C_LO;
            end
            S_C_LO: if (xfer) begin
               cnt_q   <= cnt_lo_d;
               state_q <= fin ? S_TAIL : S_DATA;
            end
            S_DATA: if (xfer) begin
               word_q <= word_d;
               bidx_q <= bidx_q + 2'd1;
               if (bidx_q == 2'd3) begin
                  state_q     <= S_WRITE;
                  in_ready_q  <= 1'b0;
                  mem_we_q    <= 1'b1;
                  mem_addr_q  <= addr_q;
                  mem_wdata_q <= word_d;
               end
            end
            S_WRITE: begin
               addr_q     <= addr_d;
               cnt_q      <= cnt_d;
               in_ready_q <= 1'b1;
               state_q    <= fin ? S_TAIL : S_DATA;
            end
`ifdef MIPS32_LOADER_CHECKSUM_EN
            S_CHK: if (chk_bad) begin
               state_q    <= S_ERR;
               in_ready_q <= 1'b0;
               err_q      <= 1'b1;
               cpu_halt_q <= 1'b1;
            end
            S_ERR: if (reload_i) begin
               state_q    <= S_IDLE;
               in_ready_q <= 1'b1;
               err_q      <= 1'b0;
               cpu_halt_q <= 1'b1;
            end
`endif
            S_DONE: if (reload_i) begin
               state_q    <= S_IDLE;
               in_ready_q <= 1'b1;
               done_q     <= 1'b0;
               cpu_halt_q <= 1'b1;
            end
            default: state_q <= S_IDLE;
         endcase

         // Entering DONE releases the CPU at the captured frame address.
         if (go_done) begin
            state_q    <= S_DONE;
            in_ready_q <= 1'b0;
            done_q     <= 1'b1;
            cpu_halt_q <= 1'b0;
            pc_start_q <= start_q;
         end
      end
   end

   assign in_ready_o  = in_ready_q;
   assign mem_we_o    = mem_we_q;
   assign mem_addr_o  = mem_addr_q;
   assign mem_wdata_o = mem_wdata_q;
   assign cpu_halt_o  = cpu_halt_q;
   assign pc_start_o  = pc_start_q;
   assign done_o      = done_q;

endmodule
